// File: rtl/run_stream_pkg.sv
// Shared types and sizing helpers for the run-length stimulus transmitter.
package run_stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_ZERO_RUN = 3;
    localparam int DEF_ONE_RUN  = 4;

    function automatic int run_max(input int zero_run, input int one_run);
        return (zero_run > one_run) ? zero_run : one_run;
    endfunction

    function automatic int run_cnt_w(input int zero_run, input int one_run);
        return $clog2(run_max(zero_run, one_run) + 1);
    endfunction

endpackage

// File: rtl/run_tracker.sv
// Tracks the current run of identical emitted bits and predicts the detector flag
// for the bit being emitted now (combinational z_next, registered by the caller).
module run_tracker
    import run_stream_pkg::*;
#(
    parameter int ZERO_RUN = DEF_ZERO_RUN,
    parameter int ONE_RUN  = DEF_ONE_RUN
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic bit_in,
    output logic z_next
);

    localparam int CNT_W   = run_cnt_w(ZERO_RUN, ONE_RUN);
    localparam int RUN_MAX = run_max(ZERO_RUN, ONE_RUN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_MAX);
    localparam logic [CNT_W-1:0] ZR_CNT  = CNT_W'(ZERO_RUN);
    localparam logic [CNT_W-1:0] OR_CNT  = CNT_W'(ONE_RUN);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
    logic             last_q, last_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
    endfunction

    // After reset count is 0, so a first bit of 0 still lands on count 1.
    always_comb begin
        cnt_next = (bit_in == last_q) ? sat_inc(cnt_q) : CNT_W'(1);
        z_next   = (!bit_in && (cnt_next >= ZR_CNT)) || (bit_in && (cnt_next >= OR_CNT));
        cnt_d    = cnt_q;
        last_d   = last_q;
        if (bit_en) begin
            cnt_d  = cnt_next;
            last_d = bit_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/run_stream_gen.sv
// Parallel-to-serial stimulus transmitter: shifts words out MSB-first and drives
// the flag a conforming run detector must raise for each emitted bit.
module run_stream_gen
    import run_stream_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ZERO_RUN = DEF_ZERO_RUN,
    parameter int ONE_RUN  = DEF_ONE_RUN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             z_exp,
    output logic             busy,
    output logic             done
);

    localparam int BCNT_W = $clog2(WIDTH);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               z_exp_q, z_exp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               xfer, emit_en, emit_bit, z_next;

    // The bit registered onto x at this edge: the new MSB on a transfer, else the
    // next pending bit of the current word.
    always_comb begin
        din_ready = (state_q == IDLE) || ((state_q == SHIFT) && (bcnt_q == LAST_BIT));
        xfer      = din_valid && din_ready;
        emit_en   = xfer || ((state_q == SHIFT) && (bcnt_q != LAST_BIT));
        emit_bit  = xfer ? din[WIDTH-1] : shreg_q[WIDTH-1];
    end

    run_tracker #(
        .ZERO_RUN (ZERO_RUN),
        .ONE_RUN  (ONE_RUN)
    ) u_run_tracker (
        .clk    (clk),
        .rst    (rst),
        .bit_en (emit_en),
        .bit_in (emit_bit),
        .z_next (z_next)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bcnt_d    = bcnt_q;
        x_d       = x_q;
        x_valid_d = 1'b0;
        z_exp_d   = 1'b0;
        done_d    = 1'b0;

        if (xfer) begin
            state_d = SHIFT;
            shreg_d = {din[WIDTH-2:0], 1'b0};
            bcnt_d  = '0;
        end else if (emit_en) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            bcnt_d  = bcnt_q + BCNT_W'(1);
        end else if (state_q == SHIFT) begin
            state_d = IDLE;
        end

        if (emit_en) begin
            x_d       = emit_bit;
            x_valid_d = 1'b1;
            z_exp_d   = z_next;
            done_d    = (bcnt_d == LAST_BIT);
        end

        busy_d = x_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            z_exp_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            z_exp_q   <= z_exp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Pending word bits are only meaningful while SHIFT, so they carry no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign z_exp   = z_exp_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_run_stream_gen.sv
// Directed bench for run_stream_gen with hand-computed serial and flag patterns.
module tb_run_stream_gen;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        x;
    logic        x_valid;
    logic        z_exp;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    logic [63:0] xs, zs, ds, vs, rs, bs;

    run_stream_gen #(
        .WIDTH    (16),
        .ZERO_RUN (3),
        .ONE_RUN  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .z_exp     (z_exp),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples n cycles at the falling edge, MSB-first into the low bits.
    task automatic cap(input int n, input int drop_at, input bit chg_din);
        xs = '0; zs = '0; ds = '0; vs = '0; rs = '0; bs = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            xs = {xs[62:0], x};
            zs = {zs[62:0], z_exp};
            ds = {ds[62:0], done};
            vs = {vs[62:0], x_valid};
            rs = {rs[62:0], din_ready};
            bs = {bs[62:0], busy};
            if (chg_din) din = 16'h5A00 + 16'(i);
            if (i == drop_at) din_valid = 1'b0;
        end
    endtask

    // Called at a falling edge; the transfer happens on the next rising edge.
    task automatic start(input logic [15:0] w);
        din       = w;
        din_valid = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_x",       64'(x),         64'h0);
        check_eq("rst_x_valid", 64'(x_valid),   64'h0);
        check_eq("rst_z_exp",   64'(z_exp),     64'h0);
        check_eq("rst_busy",    64'(busy),      64'h0);
        check_eq("rst_done",    64'(done),      64'h0);
        check_eq("rst_ready",   64'(din_ready), 64'h1);
        rst = 1'b0;

        start(16'hF0F0);
        cap(16, 0, 1'b0);
        check_eq("f0f0_x",     xs, 64'hF0F0);
        check_eq("f0f0_z",     zs, 64'h1313);
        check_eq("f0f0_done",  ds, 64'h0001);
        check_eq("f0f0_valid", vs, 64'hFFFF);
        check_eq("f0f0_busy",  bs, 64'hFFFF);
        check_eq("f0f0_ready", rs, 64'h0001);
        cap(1, -1, 1'b0);
        check_eq("idle_valid", vs, 64'h0);
        check_eq("idle_x",     xs, 64'h0);
        check_eq("idle_z",     zs, 64'h0);
        check_eq("idle_busy",  bs, 64'h0);
        check_eq("idle_ready", rs, 64'h1);

        start(16'hAAAA);
        cap(16, 0, 1'b0);
        check_eq("aaaa_x", xs, 64'hAAAA);
        check_eq("aaaa_z", zs, 64'h0);

        start(16'hFFFF);
        cap(32, 16, 1'b0);
        check_eq("b2b_x",     xs, 64'hFFFF_FFFF);
        check_eq("b2b_valid", vs, 64'hFFFF_FFFF);
        check_eq("b2b_z",     zs, 64'h1FFF_FFFF);
        check_eq("b2b_done",  ds, 64'h0001_0001);
        check_eq("b2b_ready", rs, 64'h0001_0001);

        start(16'h0003);
        cap(16, 0, 1'b0);
        check_eq("w0003_x", xs, 64'h0003);
        check_eq("w0003_z", zs, 64'h3FFC);
        cap(5, -1, 1'b0);
        check_eq("gap_valid", vs, 64'h0);
        check_eq("gap_x",     xs, 64'h1F);
        check_eq("gap_z",     zs, 64'h0);
        start(16'hC000);
        cap(16, 0, 1'b0);
        check_eq("c000_x", xs, 64'hC000);
        check_eq("c000_z", zs, 64'h4FFF);

        start(16'hFFFF);
        cap(5, 0, 1'b0);
        check_eq("pre_abort_x",     xs, 64'h1F);
        check_eq("pre_abort_valid", vs, 64'h1F);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_valid", 64'(x_valid), 64'h0);
        check_eq("abort_busy",  64'(busy),    64'h0);
        check_eq("abort_x",     64'(x),       64'h0);
        @(negedge clk);
        rst = 1'b0;
        start(16'hF000);
        cap(16, 0, 1'b0);
        check_eq("f000_x", xs, 64'hF000);
        check_eq("f000_z", zs, 64'h13FF);

        start(16'h1234);
        cap(16, -1, 1'b1);
        check_eq("hold_first_x", xs, 64'h1234);
        check_eq("hold_ready",   rs, 64'h0001);
        cap(16, 0, 1'b0);
        check_eq("hold_second_x",     xs, 64'h5A0F);
        check_eq("hold_second_valid", vs, 64'hFFFF);

        @(negedge clk);
        rst       = 1'b1;
        din       = 16'hFFFF;
        din_valid = 1'b1;
        @(negedge clk);
        check_eq("rst_vld_valid", 64'(x_valid), 64'h0);
        rst       = 1'b0;
        din_valid = 1'b0;
        cap(2, -1, 1'b0);
        check_eq("rst_vld_no_xfer", vs, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_stream_gen.md
# run_stream_gen

Serial stimulus transmitter for the run-length detector path. Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a serial line `x`. Alongside each bit it drives `z_exp`, the detection flag a conforming run detector must raise for that bit: the ZERO_RUN-th or later consecutive 0, or the ONE_RUN-th or later consecutive 1. Sits in the test/stimulus layer of the design, feeding the detector's `x` input and the scoreboard.

## Interface
- `WIDTH`, 16: bits per parallel word (≥2).
- `ZERO_RUN`, 3: run length of 0s at which `z_exp` asserts.
- `ONE_RUN`, 4: run length of 1s at which `z_exp` asserts.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `din` input WIDTH: word to transmit; bit WIDTH-1 goes out first.
- `din_valid` input 1: `din` holds a word.
- `din_ready` output 1: block accepts a word this cycle.
- `x` output 1: serial data bit.
- `x_valid` output 1: `x` and `z_exp` carry a real bit this cycle.
- `z_exp` output 1: expected detector output for the current `x` bit.
- `busy` output 1: a word is being shifted.
- `done` output 1: one-cycle pulse on the last bit of each word.

## Operation
- FSM states:
  - IDLE: `din_ready`=1, `x_valid`=0.
  - SHIFT: emits WIDTH bits.
- Transfer occurs when `din_valid` && `din_ready` are high on a rising edge. IDLE→SHIFT on transfer. SHIFT→IDLE after the last bit unless a new transfer occurs on that cycle; in that case, stay in SHIFT with no bubble.
- `din_ready` = (state==IDLE) || (state==SHIFT && bit counter == WIDTH-1). This is combinational from state.
- Shift register is loaded on transfer. Bit counter counts 0..WIDTH-1 and wraps to 0 on reload.
- Run tracker holds the last emitted bit value and a run count. The count saturates at max(ZERO_RUN, ONE_RUN).
  - Per emitted bit b: if b equals the previous bit, count+1 (saturating); otherwise count=1.
  - The first bit after reset has count=1.
  - `z_exp` = (b==0 && count≥ZERO_RUN) || (b==1 && count≥ONE_RUN).
- Run history persists across words and idle gaps. Idle cycles (`x_valid`=0) do not advance it. Consumers sample only when `x_valid`=1.
- In IDLE, `x` holds the last emitted bit and `z_exp`=0.

## Timing
- All outputs are registered except `din_ready`.
- Latency: a word accepted at edge N puts its MSB on `x` (with `x_valid`=1) after edge N. Bit k (0=MSB) is valid in cycle N+1+k.
- `z_exp` is aligned with the same cycle as its `x` bit.
- `done`=1 in the cycle carrying bit WIDTH-1. `busy`=1 in every cycle with `x_valid`=1.
- Back-to-back words give exactly WIDTH·n consecutive `x_valid` cycles.
- `din` is sampled only on the transfer edge. Changes to `din` while SHIFT is active are ignored.
- Reset values:
  - State IDLE.
  - `x`=0, `x_valid`=0, `z_exp`=0, `busy`=0, `done`=0.
  - `din_ready`=1.
  - Run count=0, last bit=0.
- Reset mid-word (asynchronous) aborts immediately: the remaining bits are discarded and the run history is cleared.
- Reset while `din_valid`=1: no transfer occurs on that edge.

## Structure
- Shared package `run_stream_pkg`:
  - State enum (IDLE, SHIFT).
  - Default WIDTH/ZERO_RUN/ONE_RUN constants.
  - Function computing the run-count width, $clog2(max(ZERO_RUN, ONE_RUN)+1).
- Sub-module `run_tracker`:
  - Inputs: `clk`, `rst`, `bit_en`, `bit_in`.
  - Output: the combinational `z_next`, registered in the top alongside `x`.
  - Contains the saturating counter and last-bit register.
- Top contains the FSM, shift register and bit counter.

## Test plan
- Reset, send 16'hF0F0 → `x` = 1111000011110000 over 16 cycles; `z_exp` by bit position = 0001001100010011 (16'h1313); `done` on the 16th cycle only.
- Send 16'hAAAA → alternating `x`, `z_exp`=0 on all 16 bits.
- Send 16'hFFFF twice with `din_valid` held → 32 contiguous `x_valid` cycles, no bubble; `z_exp`=0 on bits 1–3, then 1 on all remaining 29 bits (run saturates across the word boundary).
- Send 16'h0003, wait 5 idle cycles, send 16'hC000:
  - First word: `z_exp`=1 on bits 3–14.
  - Second word: `z_exp`=1 on bit 2 (4th consecutive 1 across the gap), then on bits 5–16.
- Assert `rst` after 5 bits of 16'hFFFF → `x_valid`, `busy`, `x` go 0 without waiting for a clock edge. Release `rst`, send 16'hF000 → `z_exp`=1 on bit 4 and bits 7–16 only (run history cleared).
- Hold `din_valid`=1 with changing `din` during SHIFT → `din_ready`=0 for bits 0–14, transfer only in the bit-15 cycle; the transmitted word equals the `din` value on that edge.
